// File: rtl/cnt_pkg.sv
// Shared constants, pick result type and round-robin search helper for the
// ticket scheduler and its arbiter.
package cnt_pkg;

  localparam int R_MAX = 16;
  localparam int PTR_W = $clog2(R_MAX);
  localparam int N_DEF = 64;

  function automatic int lo_width(input int n);
    return $clog2(n);
  endfunction

  localparam int K = lo_width(N_DEF);

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set bit of eligible at or above ptr, wrapping modulo r.
  function automatic pick_t rr_pick(input logic [R_MAX-1:0] eligible,
                                    input logic [PTR_W-1:0] ptr,
                                    input int               r);
    pick_t res;
    int    j;
    res = '0;
    for (int off = 0; off < R_MAX; off++) begin
      if (off < r) begin
        j = int'(ptr) + off;
        if (j >= r) j = j - r;
        if (!res.found && eligible[j[PTR_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[PTR_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_ticket_sched_rr_arb.sv
// Combinational round-robin pick over the eligible requesters plus the
// pointer register that rotates past each winner.
module rr_arb
  import cnt_pkg::*;
#(
  parameter int R = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [R-1:0] i_eligible,
  input  logic         i_take,
  output logic         o_found,
  output logic [R-1:0] o_onehot
);

  logic [R_MAX-1:0] w_elig;
  logic [PTR_W-1:0] w_next;
  pick_t            w_pick;
  logic [PTR_W-1:0] r_ptr;

  assign w_elig   = R_MAX'(i_eligible);
  assign w_pick   = rr_pick(w_elig, r_ptr, R);
  assign o_found  = w_pick.found;
  assign o_onehot = w_pick.found ? (R'(1) << w_pick.idx) : '0;
  assign w_next   = (w_pick.idx == PTR_W'(R - 1)) ? '0 : w_pick.idx + 1'b1;

  // The pointer only moves when a grant is actually issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_take && w_pick.found) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/cnt_ticket_sched.sv
// Round-robin ticket dispenser: each grant hands out the current value of a
// wide split counter and advances it by one, with clear/load/hold control.
module cnt_ticket_sched
  import cnt_pkg::*;
#(
  parameter int R = 4,
  parameter int N = N_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [R-1:0] i_req,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [N-1:0] i_ld_val,
  input  logic         i_hold,
  output logic [R-1:0] o_gnt,
  output logic [N-1:0] o_tkt,
  output logic         o_tkt_vld,
  output logic         o_wrap,
  output logic [N-1:0] o_count
);

  localparam int LO_W = lo_width(N);
  localparam int HI_W = N - LO_W;

  logic [LO_W-1:0] r_lo;
  logic [HI_W-1:0] r_hi;
  logic [HI_W-1:0] r_hi_inc;
  logic [R-1:0]    r_gnt;
  logic [N-1:0]    r_tkt;
  logic            r_tkt_vld;
  logic            r_wrap;

  logic [R-1:0]    w_eligible;
  logic [R-1:0]    w_onehot;
  logic            w_found;
  logic            w_take;
  logic            w_grant;
  logic [N-1:0]    w_count;
  logic [HI_W-1:0] w_ld_hi;

  assign w_eligible = i_req & ~r_gnt;
  assign w_take     = ~(i_clr | i_ld | i_hold);
  assign w_grant    = w_take & w_found;
  assign w_count    = {r_hi, r_lo};
  assign w_ld_hi    = i_ld_val[N-1:LO_W];

  rr_arb #(.R(R)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_eligible (w_eligible),
    .i_take     (w_take),
    .o_found    (w_found),
    .o_onehot   (w_onehot)
  );

  // The high field steps to a value prepared a cycle earlier; the low field
  // needs 2^LO_W increments to overflow, so the lagging refresh is always ready.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_hi_inc <= HI_W'(1);
    end else if (i_ld) begin
      r_lo     <= i_ld_val[LO_W-1:0];
      r_hi     <= w_ld_hi;
      r_hi_inc <= w_ld_hi + 1'b1;
    end else begin
      r_hi_inc <= r_hi + 1'b1;
      if (w_grant) begin
        r_lo <= r_lo + 1'b1;
        if (&r_lo) r_hi <= r_hi_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt     <= '0;
      r_tkt     <= '0;
      r_tkt_vld <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_gnt     <= w_grant ? w_onehot : '0;
      r_tkt_vld <= w_grant;
      r_wrap    <= w_grant & (&w_count);
      if (w_grant) r_tkt <= w_count;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_tkt     = r_tkt;
  assign o_tkt_vld = r_tkt_vld;
  assign o_wrap    = r_wrap;
  assign o_count   = w_count;

endmodule
